mem_if: RTL and testbench

MEM_IF -- requirements
Module: mem_if

---
 rtl/mem_if_pkg.sv | 16 +
 rtl/mem_if_if.sv | 32 +++
 rtl/mem_if_array.sv | 46 ++++
 rtl/mem_if.sv | 92 +++++++++
 tb/tb_mem_if.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/mem_if_pkg.sv
// Shared constants, word type and parity helper for the mem_if storage block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_if_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    typedef logic [DEF_WIDTH-1:0] word_t;

    // Even-parity bit for up to 32 data bits; zero-extended inputs leave the result unchanged.
    function automatic logic even_parity(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mem_if_if.sv
// Bundle of strobes, address and data between a requester and mem_if.
// Latency: n/a (wiring only). Parity ports exist only when MEM_IF_PARITY_EN is defined.
// Backpressure: none; the requester may issue one read and/or write every cycle.
interface mem_if_if
    import mem_if_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) ();

    logic                     write_en;
    logic                     read_en;
    logic [$clog2(DEPTH)-1:0] addr;
    logic [WIDTH-1:0]         data_in;
    logic [WIDTH-1:0]         data_out;
    logic                     rd_valid;
`ifdef MEM_IF_PARITY_EN
    logic                     par_inject;
    logic                     parity_err;

    modport master (output write_en, read_en, addr, data_in, par_inject,
                    input  data_out, rd_valid, parity_err);
    modport slave  (input  write_en, read_en, addr, data_in, par_inject,
                    output data_out, rd_valid, parity_err);
`else
    modport master (output write_en, read_en, addr, data_in,
                    input  data_out, rd_valid);
    modport slave  (input  write_en, read_en, addr, data_in,
                    output data_out, rd_valid);
`endif

endinterface

// File: rtl/mem_if_array.sv
// Flop-based word array with one write port and one registered read port (old data on collision).
// Latency: write lands at the strobe edge; read data appears one cycle after rd_en.
// Backpressure: none; read register holds its value when rd_en is low.
module mem_if_array #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wr_dat,
    output logic [W-1:0]  rd_dat
);

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [W-1:0]            rd_dat_q, rd_dat_d;

    // Next array contents and read register; unaddressed words and idle cycles hold.
    always_comb begin
        mem_d    = mem_q;
        rd_dat_d = rd_dat_q;
        if (wr_en) begin
            mem_d[addr] = wr_dat;
        end
        if (rd_en) begin
            rd_dat_d = mem_q[addr];
        end
    end

    // Storage is cleared as a whole by reset so no stale word survives it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            rd_dat_q <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/mem_if.sv
// Single-port word memory with write-first read forwarding and rd_valid pulse; optional parity via MEM_IF_PARITY_EN.
// Latency: read data and rd_valid one cycle after read_en; writes land at the strobe edge.
// Backpressure: none; full throughput, a read and/or write every cycle.
module mem_if
    import mem_if_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic     clk,
    input  logic     rst_n,
    mem_if_if.slave  bus
);

`ifdef MEM_IF_PARITY_EN
    localparam int SW = WIDTH + 1;   // stored word: {parity, data}
`else
    localparam int SW = WIDTH;
`endif

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("mem_if: WIDTH must be 1..32");
    end
    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mem_if: DEPTH must be a power of two in 2..256");
    end

    logic [SW-1:0] wr_word;
    logic [SW-1:0] arr_rdat;
    logic [SW-1:0] rd_word;
    logic [SW-1:0] fwd_word_q, fwd_word_d;
    logic          fwd_q, fwd_d;
    logic          rd_valid_q, rd_valid_d;

    // Word as written to storage; injection flips the parity bit to model a corrupted entry.
    always_comb begin
`ifdef MEM_IF_PARITY_EN
        wr_word = {even_parity(32'(bus.data_in)) ^ bus.par_inject, bus.data_in};
`else
        wr_word = bus.data_in;
`endif
    end

    mem_if_array #(
        .W     (SW),
        .DEPTH (DEPTH)
    ) u_array (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (bus.write_en),
        .rd_en  (bus.read_en),
        .addr   (bus.addr),
        .wr_dat (wr_word),
        .rd_dat (arr_rdat)
    );

    // A read colliding with a write returns the new word; the array itself returns old data,
    // so remember which source the latest read should use until the next read.
    always_comb begin
        fwd_d      = fwd_q;
        fwd_word_d = fwd_word_q;
        rd_valid_d = bus.read_en;
        if (bus.read_en) begin
            fwd_d = bus.write_en;
            if (bus.write_en) begin
                fwd_word_d = wr_word;
            end
        end
    end

    // Forwarding state and valid pulse; reset drops any read still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q      <= 1'b0;
            fwd_word_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            fwd_q      <= fwd_d;
            fwd_word_q <= fwd_word_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_word      = fwd_q ? fwd_word_q : arr_rdat;
    assign bus.data_out = rd_word[WIDTH-1:0];
    assign bus.rd_valid = rd_valid_q;

`ifdef MEM_IF_PARITY_EN
    assign bus.parity_err = rd_valid_q & (rd_word[WIDTH] ^ even_parity(32'(rd_word[WIDTH-1:0])));
`endif

endmodule

// File: tb/tb_mem_if.sv
// Directed bench for mem_if: reads push expected words into a queue, a monitor pops on rd_valid.
// Latency: expects data one cycle after each read strobe.
// Backpressure: none exercised; back-to-back reads are issued.
module tb_mem_if;

    logic clk;
    logic rst_n;

    mem_if_if #(.WIDTH(8), .DEPTH(16)) bus ();

    mem_if #(.WIDTH(8), .DEPTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic       perr_q[$];
    logic       pinj;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; called just after a rising edge. A read pushes its hand-computed result.
    task automatic op(input logic we, input logic re, input logic [3:0] a, input logic [7:0] din,
                      input logic [7:0] exp, input logic perr);
        bus.write_en = we;
        bus.read_en  = re;
        bus.addr     = a;
        bus.data_in  = din;
`ifdef MEM_IF_PARITY_EN
        bus.par_inject = pinj;
`endif
        if (re) begin
            exp_q.push_back(exp);
            perr_q.push_back(perr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    endtask

    // Monitor: every rd_valid pulse must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.rd_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rd_valid: got data 0x%0h with no read outstanding", bus.data_out);
                end else begin
                    logic [7:0] e;
                    logic       pe;
                    e  = exp_q.pop_front();
                    pe = perr_q.pop_front();
                    check("read_data", 32'(bus.data_out), 32'(e));
`ifdef MEM_IF_PARITY_EN
                    check("parity_err", 32'(bus.parity_err), 32'(pe));
`else
                    if (pe) $display("note: parity expectation ignored without parity build");
`endif
                end
            end
        end
    end

    initial begin
        pinj         = 1'b0;
        rst_n        = 1'b0;
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
        bus.addr     = '0;
        bus.data_in  = '0;
`ifdef MEM_IF_PARITY_EN
        bus.par_inject = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_data_out", 32'(bus.data_out), 32'h00);
        check("reset_rd_valid", 32'(bus.rd_valid), 32'h0);
        rst_n = 1'b1;

        // Fresh memory reads as zero.
        op(1'b0, 1'b1, 4'd5, 8'h00, 8'h00, 1'b0);
        // Write then read next cycle.
        op(1'b1, 1'b0, 4'd0, 8'hFF, 8'h00, 1'b0);
        op(1'b0, 1'b1, 4'd0, 8'h00, 8'hFF, 1'b0);
        // Same-cycle read and write returns the new data.
        op(1'b1, 1'b1, 4'd3, 8'hA5, 8'hA5, 1'b0);
        // Back-to-back reads.
        op(1'b1, 1'b0, 4'd0, 8'h11, 8'h00, 1'b0);
        op(1'b1, 1'b0, 4'd1, 8'h22, 8'h00, 1'b0);
        op(1'b1, 1'b0, 4'd2, 8'h33, 8'h00, 1'b0);
        op(1'b0, 1'b1, 4'd0, 8'h00, 8'h11, 1'b0);
        op(1'b0, 1'b1, 4'd1, 8'h00, 8'h22, 1'b0);
        op(1'b0, 1'b1, 4'd2, 8'h00, 8'h33, 1'b0);
        // Idle cycles hold the last read value.
        idle();
        idle();
        check("hold_after_idle", 32'(bus.data_out), 32'h33);
        check("no_valid_when_idle", 32'(bus.rd_valid), 32'h0);
        // Top address is distinct from address 0.
        op(1'b1, 1'b0, 4'd15, 8'h5A, 8'h00, 1'b0);
        op(1'b0, 1'b1, 4'd15, 8'h00, 8'h5A, 1'b0);
        op(1'b0, 1'b1, 4'd0, 8'h00, 8'h11, 1'b0);
        // A write alone must not disturb data_out.
        op(1'b1, 1'b0, 4'd4, 8'h77, 8'h00, 1'b0);
        check("hold_after_write", 32'(bus.data_out), 32'h11);
        op(1'b0, 1'b1, 4'd4, 8'h00, 8'h77, 1'b0);
        // Forwarded read followed by a plain read must come from storage again.
        op(1'b1, 1'b1, 4'd9, 8'h42, 8'h42, 1'b0);
        op(1'b0, 1'b1, 4'd3, 8'h00, 8'hA5, 1'b0);

        // Reset in the middle of a read: that read is dropped, memory cleared.
        op(1'b1, 1'b0, 4'd7, 8'h3C, 8'h00, 1'b0);
        bus.write_en = 1'b0;
        bus.read_en  = 1'b1;
        bus.addr     = 4'd7;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rd_valid_in_reset", 32'(bus.rd_valid), 32'h0);
            check("data_out_in_reset", 32'(bus.data_out), 32'h00);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        op(1'b0, 1'b1, 4'd7, 8'h00, 8'h00, 1'b0);
        op(1'b0, 1'b1, 4'd0, 8'h00, 8'h00, 1'b0);
        op(1'b1, 1'b0, 4'd7, 8'h3C, 8'h00, 1'b0);
        op(1'b0, 1'b1, 4'd7, 8'h00, 8'h3C, 1'b0);

`ifdef MEM_IF_PARITY_EN
        // Injected parity error is flagged; a clean rewrite is not.
        pinj = 1'b1;
        op(1'b1, 1'b0, 4'd6, 8'h01, 8'h00, 1'b0);
        pinj = 1'b0;
        op(1'b0, 1'b1, 4'd6, 8'h00, 8'h01, 1'b1);
        op(1'b1, 1'b0, 4'd6, 8'h01, 8'h00, 1'b0);
        op(1'b0, 1'b1, 4'd6, 8'h00, 8'h01, 1'b0);
`endif

        idle();
        // Bounded drain of outstanding expectations.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        check("outstanding_reads", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
